grf: RTL

General register file for the single-cycle MIPS datapath: 32 × 32-bit registers, two combinational read ports, one clocked write port. It is the producing end of the ALU operand path: read port 2 supplies the register operand that the ALU-source selector chooses against the extended immediate, and read port 1 supplies ALU operand A. It also emits a registered write-commit trace that the bench and the course judge use to check architectural state.

---
 rtl/mips_pkg.sv | 19 +
 rtl/grf_bypass.sv | 24 ++
 rtl/grf.sv | 93 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared widths, register-file constants and the write-commit trace record
// for the single-cycle MIPS datapath.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int REG_NUM = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_trace_t;

endpackage

// File: rtl/grf_bypass.sv
// Combinational read path for one register-file port: $0 reads zero, and a
// write in flight to the same register is forwarded ahead of storage.
module grf_bypass
  import mips_pkg::*;
(
  input  logic [ADDR_W-1:0] ra,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] rd
);

  always_comb begin
    if (ra == REG_ZERO) begin
      rd = '0;
    end else if (regwrite && (wa == ra)) begin
      rd = wd;
    end else begin
      rd = stored;
    end
  end

endmodule

// File: rtl/grf.sv
// 32 x 32-bit general register file: two bypassed combinational read ports,
// one clocked write port and a registered write-commit trace.
module grf
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [31:0]       pc,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              wr_valid,
  output logic [31:0]       wr_pc,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  // $0 has no storage; the read view ties slot 0 to zero.
  logic [DATA_W-1:0] regs_q  [1:REG_NUM-1];
  logic [DATA_W-1:0] regs_d  [1:REG_NUM-1];
  logic [DATA_W-1:0] rf_view [REG_NUM];
  wr_trace_t         trace_q, trace_d;
  logic              commit;

  // NOTE: every signal assigned here gets a value on every path, otherwise
  // synthesis infers a latch to hold the missing case.
  always_comb begin
    commit = regwrite && (wa != REG_ZERO);
    for (int i = 1; i < REG_NUM; i++) begin
      regs_d[i] = (commit && (wa == ADDR_W'(i))) ? wd : regs_q[i];
    end

    trace_d       = trace_q;
    trace_d.valid = commit;
    if (commit) begin
      trace_d.pc   = pc;
      trace_d.addr = wa;
      trace_d.data = wd;
    end
  end

  // NOTE: the storage array is cleared by reset because architectural state
  // must read zero after reset; non-blocking assignments keep every flop
  // sampling pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
      trace_q <= '0;
    end else begin
      for (int i = 1; i < REG_NUM; i++) begin
        regs_q[i] <= regs_d[i];
      end
      trace_q <= trace_d;
    end
  end

  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < REG_NUM; i++) begin
      rf_view[i] = regs_q[i];
    end
  end

  grf_bypass u_bypass_1 (
    .ra       (ra1),
    .regwrite (regwrite),
    .wa       (wa),
    .wd       (wd),
    .stored   (rf_view[ra1]),
    .rd       (rd1)
  );

  grf_bypass u_bypass_2 (
    .ra       (ra2),
    .regwrite (regwrite),
    .wa       (wa),
    .wd       (wd),
    .stored   (rf_view[ra2]),
    .rd       (rd2)
  );

  assign wr_valid = trace_q.valid;
  assign wr_pc    = trace_q.pc;
  assign wr_addr  = trace_q.addr;
  assign wr_data  = trace_q.data;

endmodule
